// File: rtl/uart_tx_peripheral_pkg.sv
// rtl/uart_tx_peripheral_pkg.sv - shared decode constants, STATUS layout and FSM encodings for the UART TX block
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_peripheral_pkg;

    localparam logic [2:0] SEL_CODE = 3'b010;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - power-of-two byte FIFO feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// rtl/uart_tx_peripheral.sv - memory-mapped UART transmitter: register decode, baud counter and frame FSM
// Defining UART_TX_PARITY_EN adds an even parity bit between data bit 7 and the stop bit.
module uart_tx_peripheral
    import uart_tx_peripheral_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     next_state;
    logic [15:0]   bauddiv;
    logic [15:0]   baud_cnt;
    logic [15:0]   baud_reload;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shreg;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic          bit_done;
    logic          tx_next;
    logic          pop;
    logic          push;
    logic          push_req;
    logic          sel;
    logic          wr;
    logic          rd;
    logic [1:0]    offset;
    logic [31:0]   status;
    logic [31:0]   rd_data;
    logic          unused_bits;

    assign sel         = (addr[31:29] == SEL_CODE);
    assign offset      = addr[3:2];
    assign wr          = write_enable && sel;
    assign rd          = read_enable && sel;
    assign push_req    = wr && (offset == OFF_TXDATA);
    assign push        = push_req && !fifo_full;
    assign unused_bits = ^{addr[28:4], addr[1:0], data_in[31:16]};

    // A divider of zero behaves as one clock per bit.
    assign baud_reload = (bauddiv == 16'd0) ? 16'd0 : bauddiv - 16'd1;
    assign bit_done    = (baud_cnt == 16'd0);
    assign irq         = fifo_empty && (state == S_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (data_in[7:0]),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status                                 = '0;
        status[ST_BUSY]                        = (state != S_IDLE);
        status[ST_FULL]                        = fifo_full;
        status[ST_EMPTY]                       = fifo_empty;
        status[ST_OVF]                         = overflow;
        status[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_STATUS:  rd_data = status;
            OFF_BAUDDIV: rd_data = {16'd0, bauddiv};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bauddiv  <= BAUD_DIV_RESET;
            overflow <= 1'b0;
            data_out <= '0;
        end else begin
            if (wr && (offset == OFF_BAUDDIV)) bauddiv <= data_in[15:0];
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (rd && (offset == OFF_STATUS)) begin
                overflow <= 1'b0;
            end
            if (rd) begin
                data_out <= rd_data;
            end else if ((read_enable || write_enable) && !sel) begin
                data_out <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        bit_idx_next = bit_idx;
        tx_next      = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    next_state = S_START;
                    pop        = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    next_state   = S_DATA;
                    bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) next_state = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        next_state = S_START;
                        pop        = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
        // tx is registered from the next state so the line changes with the state.
        case (next_state)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shreg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = ^shreg;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    // The divider is reloaded at every bit boundary, so BAUDDIV writes apply to the next bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
            if (pop) shreg <= fifo_data;
            if ((state == S_IDLE) || bit_done) baud_cnt <= baud_reload;
            else                               baud_cnt <= baud_cnt - 16'd1;
        end
    end

endmodule
